// File: rtl/i2c_target_responder.sv
// i2c_target_responder: 7-bit-addressed I2C target with RX/TX valid-ready FIFOs and open-drain SDA.
module i2c_target_responder #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS = 7'h09,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic                      busy_o,
  output logic                      rx_overflow_o,
  output logic                      tx_underrun_o
);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DW) + 1;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_IGNORE   = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WR_DATA  = 4'd4;
  localparam logic [3:0] S_WR_ACK   = 4'd5;
  localparam logic [3:0] S_RD_DATA  = 4'd6;
  localparam logic [3:0] S_RD_ACK   = 4'd7;
  localparam logic [3:0] S_RD_WAIT  = 4'd8;
  logic          scl_s1, scl_s2, scl_p, sda_s1, sda_s2, sda_p;
  logic          scl_rise, scl_fall, start_c, stop_c, last_bit, load, tx_pop;
  logic [3:0]    state;
  logic [DW-1:0] sh, next_byte, tx_byte;
  logic [CW-1:0] bcnt;
  logic          phase, rw, nack, rx_push;
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wr, rx_rd, tx_wr, tx_rd;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  // Synchronizers idle high so reset never fabricates a bus condition.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {scl_s1, scl_s2, scl_p, sda_s1, sda_s2, sda_p} <= '1;
    else {scl_s1, scl_s2, scl_p, sda_s1, sda_s2, sda_p} <= {scl_i, scl_s1, scl_s2, sda_i, sda_s1, sda_s2};
  assign scl_rise  = scl_s2 & ~scl_p;
  assign scl_fall  = ~scl_s2 & scl_p;
  assign start_c   = scl_s2 & scl_p & sda_p & ~sda_s2;
  assign stop_c    = scl_s2 & scl_p & ~sda_p & sda_s2;
  assign next_byte = {sh[DW-2:0], sda_s2};
  assign last_bit  = bcnt == CW'(DW - 1);
  assign rx_empty  = rx_wr == rx_rd;
  assign rx_full   = (rx_wr ^ rx_rd) == {1'b1, {AW{1'b0}}};
  assign tx_empty  = tx_wr == tx_rd;
  assign tx_full   = (tx_wr ^ tx_rd) == {1'b1, {AW{1'b0}}};
  assign rx_valid_o = ~rx_empty;
  assign tx_ready_o = ~tx_full;
  assign rx_data_o  = rx_mem[rx_rd[AW-1:0]];
  assign tx_byte    = tx_empty ? '1 : tx_mem[tx_rd[AW-1:0]];
  // A byte is fetched at the end of the address ACK (read) or on a master ACK.
  assign load   = (state == S_ADDR_ACK & scl_fall & phase & rw) | (state == S_RD_ACK & scl_rise & ~sda_s2);
  assign tx_pop = load & ~tx_empty;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state         <= S_IDLE;
      sda_o         <= 1'b1;
      busy_o        <= 1'b0;
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
      sh            <= '0;
      bcnt          <= '0;
      phase         <= 1'b0;
      rw            <= 1'b0;
      nack          <= 1'b0;
      rx_push       <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (start_c) begin
        state         <= S_ADDR;
        bcnt          <= '0;
        phase         <= 1'b0;
        sda_o         <= 1'b1;
        rx_overflow_o <= 1'b0;
        tx_underrun_o <= 1'b0;
      end else if (stop_c) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
        sda_o  <= 1'b1;
        phase  <= 1'b0;
      end else begin
        case (state)
          S_ADDR:
            if (scl_rise) begin
              sh   <= next_byte;
              bcnt <= bcnt + 1'b1;
              if (last_bit) begin
                rw     <= next_byte[0];
                state  <= next_byte[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDRESS ? S_ADDR_ACK : S_IGNORE;
                busy_o <= next_byte[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDRESS;
              end
            end
          // phase 0: first fall starts the ACK bit; phase 1: second fall ends it.
          S_ADDR_ACK:
            if (scl_fall) begin
              phase <= ~phase;
              if (!phase) sda_o <= 1'b0;
              else if (rw) begin
                sh    <= {tx_byte[DW-2:0], 1'b0};
                sda_o <= tx_byte[DW-1];
                bcnt  <= CW'(1);
                state <= S_RD_DATA;
                if (tx_empty) tx_underrun_o <= 1'b1;
              end else begin
                sda_o <= 1'b1;
                bcnt  <= '0;
                state <= S_WR_DATA;
              end
            end
          S_WR_DATA:
            if (scl_rise) begin
              sh   <= next_byte;
              bcnt <= bcnt + 1'b1;
              if (last_bit) begin
                state   <= S_WR_ACK;
                nack    <= rx_full;
                rx_push <= ~rx_full;
                if (rx_full) rx_overflow_o <= 1'b1;
              end
            end
          S_WR_ACK:
            if (scl_fall) begin
              phase <= ~phase;
              if (!phase) sda_o <= nack;
              else begin
                sda_o <= 1'b1;
                bcnt  <= '0;
                state <= S_WR_DATA;
              end
            end
          // sh holds the bits still to be driven, MSB first.
          S_RD_DATA:
            if (scl_fall) begin
              if (bcnt == CW'(DW)) begin
                sda_o <= 1'b1;
                state <= S_RD_ACK;
              end else begin
                sda_o <= sh[DW-1];
                sh    <= sh << 1;
                bcnt  <= bcnt + 1'b1;
              end
            end
          S_RD_ACK:
            if (scl_rise) begin
              if (!sda_s2) begin
                sh    <= tx_byte;
                bcnt  <= '0;
                state <= S_RD_DATA;
                if (tx_empty) tx_underrun_o <= 1'b1;
              end else state <= S_RD_WAIT;
            end
          default: ;
        endcase
      end
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rx_wr <= '0;
      rx_rd <= '0;
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_valid_o & rx_ready_i) rx_rd <= rx_rd + 1'b1;
      if (tx_valid_i & tx_ready_o) tx_wr <= tx_wr + 1'b1;
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
    end
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= sh;
    if (tx_valid_i & tx_ready_o) tx_mem[tx_wr[AW-1:0]] <= tx_data_i;
  end
endmodule
